// File: rtl/sysid_reader.sv
// sysid_reader: reads the system ID (word 0) and build timestamp (word 1)
// from an Avalon-MM sysid slave. Each read is bounded by a waitrequest
// timeout. Reports pass/timeout status and the captured words.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1367779031,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD_ID = 2'd1;
  localparam logic [1:0] RD_TS = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  // Out-of-range timeouts would make the 16-bit counter wrap or fire at once.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("sysid_reader: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic rd_ack;
  logic rd_tmo;

  // Read handshake qualifiers; only meaningful in the two read states.
  always_comb begin
    rd_ack = avm_read_q && !avm_waitrequest;
    // Completion takes priority: a timeout needs waitrequest still high.
    rd_tmo = avm_read_q && avm_waitrequest && (wait_cnt_q == TimeoutLimit);
  end

  // Next-state and registered-output computation for the check sequence.
  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          timeout_err_d = 1'b0;
          id_value_d    = 32'd0;
          ts_value_d    = 32'd0;
          wait_cnt_d    = 16'd0;
        end
      end

      RD_ID: begin
        if (rd_ack) begin
          // Go straight into the timestamp read; avm_read stays high.
          id_value_d    = avm_readdata;
          state_d       = RD_TS;
          avm_address_d = 1'b1;
          wait_cnt_d    = 16'd0;
        end else if (rd_tmo) begin
          state_d       = FIN;
          avm_read_d    = 1'b0;
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
          done_d        = 1'b1;
        end else if (avm_waitrequest) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      RD_TS: begin
        if (rd_ack) begin
          ts_value_d = avm_readdata;
          state_d    = FIN;
          avm_read_d = 1'b0;
          done_d     = 1'b1;
          // Timestamp is compared as it arrives so pass is valid with done.
          pass_d     = (id_value_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
        end else if (rd_tmo) begin
          state_d       = FIN;
          avm_read_d    = 1'b0;
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
          done_d        = 1'b1;
        end else if (avm_waitrequest) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      FIN: begin
        // start is not looked at here, so a request in this cycle is dropped.
        state_d       = IDLE;
        busy_d        = 1'b0;
        avm_address_d = 1'b0;
      end

      default: begin
        state_d       = IDLE;
        avm_read_d    = 1'b0;
        avm_address_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
      wait_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  // Outputs come straight from flops; no input reaches them combinationally.
  always_comb begin
    avm_address = avm_address_q;
    avm_read    = avm_read_q;
    busy        = busy_q;
    done        = done_q;
    pass        = pass_q;
    timeout_err = timeout_err_q;
    id_value    = id_value_q;
    ts_value    = ts_value_q;
  end

`ifndef SYNTHESIS
  // Simulation-only sanity checks on status and bus behaviour.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(pass_q && timeout_err_q))
        else $error("sysid_reader: pass and timeout_err both set");
      assert (!done_q || state_q == FIN)
        else $error("sysid_reader: done outside FIN");
      if (avm_read_q && avm_waitrequest && !rd_tmo && state_q != IDLE) begin
        assert (avm_address_d == avm_address_q)
          else $error("sysid_reader: address changed during stall");
      end
    end
  end
`endif

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: randomized sequences against a transaction-level
// model; expectations are queued at start and checked when done pulses.
module tb_sysid_reader;

  localparam int unsigned T   = 4;
  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'd1367779031;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_reader #(
    .EXPECTED_ID       (EID),
    .EXPECTED_TIMESTAMP(ETS),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    else n_pass++;
  endtask

  // Slave: each address stalls for sl_wait[addr] cycles, then returns sl_data[addr].
  int unsigned sl_wait [2];
  logic [31:0] sl_data [2];
  int unsigned rd_cnt = 0;

  always_comb begin
    avm_waitrequest = avm_read && (rd_cnt < sl_wait[avm_address]);
    avm_readdata    = sl_data[avm_address];
  end

  always @(posedge clock) begin
    if (reset || !avm_read || !avm_waitrequest) rd_cnt <= 0;
    else rd_cnt <= rd_cnt + 1;
  end

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        pass;
    logic        terr;
    int unsigned done_cyc;
    int unsigned rd_cycles;
  } exp_t;

  exp_t q[$];

  // Whole-transaction model: a read with w stall cycles takes w+1 cycles
  // unless w exceeds T, in which case it is abandoned after T+1 cycles.
  function automatic exp_t model(input int unsigned w0, input int unsigned w1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input int unsigned sc);
    exp_t e;
    bit to0 = (w0 > T);
    bit to1 = (w1 > T);
    int unsigned l0 = to0 ? T + 1 : w0 + 1;
    int unsigned l1 = to1 ? T + 1 : w1 + 1;
    e.id = to0 ? 32'd0 : d0;
    if (to0) begin
      e.ts = 32'd0; e.terr = 1'b1; e.pass = 1'b0; e.rd_cycles = l0;
    end else begin
      e.ts        = to1 ? 32'd0 : d1;
      e.terr      = to1;
      e.pass      = !to1 && (d0 == EID) && (d1 == ETS);
      e.rd_cycles = l0 + l1;
    end
    e.done_cyc = sc + 1 + e.rd_cycles;
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  int unsigned rd_seen = 0;
  exp_t        m;
  always @(negedge clock) begin
    if (reset) begin
      rd_seen = 0;
    end else begin
      if (avm_read) rd_seen++;
      if (done) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          m = q.pop_front();
          chk("id_value", id_value, m.id);
          chk("ts_value", ts_value, m.ts);
          chk("pass", {31'd0, pass}, {31'd0, m.pass});
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, m.terr});
          chk("done_cycle", cyc, m.done_cyc);
          chk("read_cycles", rd_seen, m.rd_cycles);
          chk("pass_and_terr", {31'd0, pass && timeout_err}, 32'd0);
        end
        rd_seen = 0;
      end
    end
  end

  exp_t last;

  task automatic check_all_zero(input string tag);
    chk({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
    chk({tag, "_avm_address"}, {31'd0, avm_address}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_id_value"}, id_value, 32'd0);
    chk({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  // One sequence from idle; spam re-pulses start while busy (incl. the FIN cycle).
  task automatic run_seq(input int unsigned w0, input int unsigned w1,
                         input logic [31:0] d0, input logic [31:0] d1, input bit spam);
    bit got = 0;
    sl_wait[0] = w0; sl_wait[1] = w1;
    sl_data[0] = d0; sl_data[1] = d1;
    @(posedge clock); #1;
    start = 1'b1;
    last = model(w0, w1, d0, d1, cyc);
    q.push_back(last);
    @(posedge clock); #1;
    for (int k = 0; k < 200; k++) begin
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
      if (done) begin got = 1; break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    start = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL done_wait_bound: no done within 200 cycles, expected by cycle %0d", last.done_cyc);
      q.delete();
    end
    // Status must be held and no hidden sequence may have started.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_avm_read", {31'd0, avm_read}, 32'd0);
    chk("held_pass", {31'd0, pass}, {31'd0, last.pass});
    chk("held_timeout_err", {31'd0, timeout_err}, {31'd0, last.terr});
    chk("held_id_value", id_value, last.id);
    chk("held_ts_value", ts_value, last.ts);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          saw;
    bit          found;
    int unsigned w0, w1;
    logic [31:0] d0, d1;

    sl_wait[0] = 0; sl_wait[1] = 0;
    sl_data[0] = EID; sl_data[1] = ETS;

    // Start held high during reset must be ignored.
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    // Fast slave, matching words.
    run_seq(0, 0, EID, ETS, 0);
    // Timestamp off by one.
    run_seq(0, 0, EID, ETS - 32'd1, 0);
    // Three stall cycles per read.
    run_seq(3, 3, EID, ETS, 0);
    // Stuck waitrequest: abort during the ID read.
    run_seq(1000, 1000, EID, ETS, 0);
    // ID read fine, timestamp read stuck.
    run_seq(0, 1000, EID, ETS, 0);
    // Stall exactly at the limit still completes.
    run_seq(T, T, EID, ETS, 1);

    // Re-pulse start while busy, then reset during the timestamp read.
    sl_wait[0] = 0; sl_wait[1] = 3;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (avm_read && avm_address) begin found = 1; break; end
    end
    chk("reach_rd_ts", {31'd0, found}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("midreset");
    saw = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done || busy) saw = 1;
    end
    chk("no_activity_after_reset", {31'd0, saw}, 32'd0);

    run_seq(0, 0, EID, ETS, 0);

    // Randomized sequences.
    for (int n = 0; n < 40; n++) begin
      w0 = $urandom_range(0, T + 2);
      w1 = $urandom_range(0, T + 2);
      d0 = ($urandom_range(0, 3) == 0) ? $urandom : EID;
      case ($urandom_range(0, 3))
        0:       d1 = $urandom;
        1:       d1 = ETS ^ (32'd1 << $urandom_range(0, 31));
        default: d1 = ETS;
      endcase
      run_seq(w0, w1, d0, d1, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clock);
    chk("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
